cnn_ram_dump: RTL and testbench

//  Readback path for the 1-bit input image RAM: reads bits sequentially from address 0.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/cnn_bit_packer8.sv | 78 +++++++
 rtl/cnn_ram_dump.sv | 131 +++++++++++++
 tb/tb_cnn_ram_dump.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN image RAM readback path.
// The dump FSM state encoding lives here so bench and RTL agree on names.
package cnn_pkg;

   localparam int         DUMP_ADDR_W = 10;
   localparam int         IMG_BITS    = 784;
   localparam logic [7:0] FRAME_HDR   = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FETCH,
      ST_SEND,
      ST_WAIT,
      ST_CSUM,
      ST_CWAIT,
      ST_FIN
   } dump_state_t;

endpackage

// File: rtl/cnn_bit_packer8.sv
// Reads up to 8 consecutive bits from the 1-bit image RAM and packs them LSB first.
// Positions at or beyond the limit are never addressed and pack as 0.
module cnn_bit_packer8 #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              start,
   input  logic [ADDR_W:0]   base,
   input  logic [ADDR_W:0]   limit,
   input  logic              din,
   output logic [ADDR_W-1:0] addr_rd,
   output logic              valid,
   output logic [7:0]        byte_out
);

   logic            issuing;
   logic [2:0]      idx;
   logic [ADDR_W:0] cur;
   logic            in_range;
   logic            s1_act, s1_rd, s1_last;
   logic            s2_act, s2_rd, s2_last;
   logic [7:0]      shreg;

   assign cur      = base + (ADDR_W+1)'(idx);
   assign in_range = issuing && (cur < limit);
   assign byte_out = shreg;

   // s1 lines up with addr_rd on the bus, s2 with the RAM data it returns.
   // NOTE: every register here, including the shift register, is a plain flop
   // with a known reset value; non-blocking assignments keep the pipeline
   // stages from racing each other within one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issuing <= 1'b0;
         idx     <= '0;
         addr_rd <= '0;
         s1_act  <= 1'b0;
         s1_rd   <= 1'b0;
         s1_last <= 1'b0;
         s2_act  <= 1'b0;
         s2_rd   <= 1'b0;
         s2_last <= 1'b0;
         shreg   <= '0;
         valid   <= 1'b0;
      end else begin
         valid   <= 1'b0;
         s1_act  <= issuing;
         s1_rd   <= in_range;
         s1_last <= issuing && (idx == 3'd7);
         s2_act  <= s1_act;
         s2_rd   <= s1_rd;
         s2_last <= s1_last;

         if (clr)
            addr_rd <= '0;
         else if (in_range)
            addr_rd <= cur[ADDR_W-1:0];

         if (s2_act) begin
            shreg <= {s2_rd & din, shreg[7:1]};
            valid <= s2_last;
         end

         if (start) begin
            issuing <= 1'b1;
            idx     <= '0;
            shreg   <= '0;
         end else if (issuing) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7)
               issuing <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cnn_ram_dump.sv
// Dumps the 1-bit input image RAM over the shared UART TX as
// header, LSB-first packed payload bytes, and an XOR checksum of the payload.
module cnn_ram_dump
   import cnn_pkg::*;
#(
   parameter int         ADDR_W   = DUMP_ADDR_W,
   parameter int         MAX_BITS = IMG_BITS,
   parameter logic [7:0] HDR_BYTE = FRAME_HDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              strt,
   input  logic [ADDR_W-1:0] nbits,
   output logic [ADDR_W-1:0] addr_rd,
   input  logic              din,
   output logic              trmt,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              bsy,
   output logic              done
);

   localparam int              CW      = ADDR_W + 1;
   localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BITS);

   dump_state_t   state, state_nxt;
   logic [CW-1:0] nbits_q;
   logic [CW-1:0] nbits_clamped;
   logic [CW-1:0] bit_cnt;
   logic [7:0]    csum;
   logic          accept;
   logic          pk_start;
   logic          pk_valid;
   logic [7:0]    pk_byte;
   logic          tx_ack;
   logic          more;

   assign nbits_clamped = ({1'b0, nbits} > MAX_CNT) ? MAX_CNT : {1'b0, nbits};
   // A tx_done coinciding with our own trmt pulse cannot belong to this byte.
   assign tx_ack        = tx_done && !trmt;
   assign more          = bit_cnt < nbits_q;

   cnn_bit_packer8 #(.ADDR_W(ADDR_W)) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .start    (pk_start),
      .base     (bit_cnt),
      .limit    (nbits_q),
      .din      (din),
      .addr_rd  (addr_rd),
      .valid    (pk_valid),
      .byte_out (pk_byte)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pk_start  = 1'b0;
      case (state)
         ST_IDLE:  if (strt) begin
                      accept    = 1'b1;
                      state_nxt = ST_HDR;
                   end
         ST_HDR:   state_nxt = ST_WAIT;
         ST_FETCH: if (pk_valid) state_nxt = ST_SEND;
         ST_SEND:  state_nxt = ST_WAIT;
         ST_WAIT:  if (tx_ack) begin
                      if (more) begin
                         pk_start  = 1'b1;
                         state_nxt = ST_FETCH;
                      end else begin
                         state_nxt = ST_CSUM;
                      end
                   end
         ST_CSUM:  state_nxt = ST_CWAIT;
         ST_CWAIT: if (tx_ack) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         nbits_q <= '0;
         bit_cnt <= '0;
         csum    <= '0;
         trmt    <= 1'b0;
         tx_data <= '0;
         bsy     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         trmt  <= 1'b0;
         done  <= 1'b0;

         if (accept) begin
            nbits_q <= nbits_clamped;
            bit_cnt <= '0;
            csum    <= '0;
            bsy     <= 1'b1;
         end

         case (state)
            ST_HDR: begin
               tx_data <= HDR_BYTE;
               trmt    <= 1'b1;
            end
            ST_SEND: begin
               tx_data <= pk_byte;
               csum    <= csum ^ pk_byte;
               bit_cnt <= bit_cnt + CW'(8);
               trmt    <= 1'b1;
            end
            ST_CSUM: begin
               tx_data <= csum;
               trmt    <= 1'b1;
            end
            ST_CWAIT: if (tx_ack) begin
               done <= 1'b1;
               bsy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_ram_dump.sv
// Directed bench for cnn_ram_dump: RAM and UART models, byte capture, immediate-assert checks.
module tb_cnn_ram_dump;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       strt;
   logic [9:0] nbits;
   logic [9:0] addr_rd;
   logic       din;
   logic       trmt;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       resp_done;
   logic       stray_done;
   logic       bsy;
   logic       done;

   logic       mem [0:1023];
   logic [7:0] byte_q [$];
   logic [7:0] exp_q [$];
   logic       rand_dly = 1'b0;
   logic       outstanding = 1'b0;
   logic       bsy_d = 1'b0;
   int         done_cnt = 0;
   int         viol = 0;
   int         unstable = 0;
   int         addr_max = 0;
   int         checks = 0;
   int         errors = 0;

   assign tx_done = resp_done | stray_done;

   always #5 clk = ~clk;

   cnn_ram_dump dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .strt    (strt),
      .nbits   (nbits),
      .addr_rd (addr_rd),
      .din     (din),
      .trmt    (trmt),
      .tx_data (tx_data),
      .tx_done (tx_done),
      .bsy     (bsy),
      .done    (done)
   );

   // Synchronous RAM: data for the address seen this cycle appears next cycle.
   always @(posedge clk) din <= mem[addr_rd];

   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding <= 1'b0;
         bsy_d       <= 1'b0;
      end else begin
         if (trmt) begin
            byte_q.push_back(tx_data);
            if (outstanding) viol <= viol + 1;
            outstanding <= 1'b1;
         end else if (tx_done) begin
            outstanding <= 1'b0;
         end
         if (done) done_cnt <= done_cnt + 1;
         if (bsy && !bsy_d) addr_max <= int'(addr_rd);
         else if (bsy && int'(addr_rd) > addr_max) addr_max <= int'(addr_rd);
         bsy_d <= bsy;
      end
   end

   // UART responder: acknowledges each trmt after a delay, watching tx_data hold.
   initial begin
      logic [7:0] hold;
      int         n;
      resp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && trmt) begin
            hold = tx_data;
            n    = rand_dly ? int'($urandom_range(0, 200)) : 2;
            for (int k = 0; k < n + 1 && rst_n; k++) begin
               @(negedge clk);
               if (rst_n && tx_data !== hold) unstable++;
            end
            if (rst_n) begin
               resp_done = 1'b1;
               @(negedge clk);
               resp_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic load_byte(input int a, input logic [7:0] b);
      for (int i = 0; i < 8; i++) mem[a + i] = b[i];
   endtask

   task automatic build_exp(input int nb);
      logic [7:0] b;
      logic [7:0] cs;
      cs = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < (nb + 7) / 8; k++) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++)
            if (8 * k + i < nb) b[i] = mem[8 * k + i];
         exp_q.push_back(b);
         cs = cs ^ b;
      end
      exp_q.push_back(cs);
   endtask

   task automatic check_frame(input string tag, input int base);
      chk({tag, "_len"}, byte_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (base + i < byte_q.size())
            chk($sformatf("%s_byte%0d", tag, i), byte_q[base + i], exp_q[i]);
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, seen, 1);
   endtask

   task automatic finish_frame(input string tag, input int budget, input int dbase);
      wait_done(tag, budget);
      repeat (4) @(negedge clk);
      chk({tag, "_done_once"}, done_cnt - dbase, 1);
      chk({tag, "_bsy_low"}, bsy, 0);
   endtask

   task automatic run_frame(input string tag, input logic [9:0] nb, input int budget,
                            output int base);
      int dbase;
      base  = byte_q.size();
      dbase = done_cnt;
      nbits = nb;
      strt  = 1'b1;
      @(negedge clk);
      strt  = 1'b0;
      finish_frame(tag, budget, dbase);
   endtask

   initial begin
      int base;
      int dbase;
      int ubase;
      rst_n      = 1'b0;
      strt       = 1'b0;
      nbits      = '0;
      stray_done = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_addr", addr_rd, 0);
      chk("rst_trmt", trmt, 0);
      chk("rst_txdata", tx_data, 0);
      chk("rst_bsy", bsy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Two full bytes.
      load_byte(0, 8'h5A);
      load_byte(8, 8'hC3);
      run_frame("t1", 10'd16, 2000, base);
      exp_q = {8'hA5, 8'h5A, 8'hC3, 8'h99};
      check_frame("t1", base);
      chk("t1_maxaddr", addr_max, 15);

      // Empty payload: header then a zero checksum only.
      run_frame("t2", 10'd0, 2000, base);
      exp_q = {8'hA5, 8'h00};
      check_frame("t2", base);
      chk("t2_maxaddr", addr_max, 0);

      // Slow UART, stray tx_done during FETCH and an ignored second strt.
      rand_dly = 1'b1;
      ubase    = unstable;
      base     = byte_q.size();
      dbase    = done_cnt;
      nbits    = 10'd16;
      strt     = 1'b1;
      @(negedge clk);
      strt     = 1'b0;
      for (int i = 0; i < 1000 && !(byte_q.size() > base && !outstanding); i++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      nbits      = 10'd8;
      strt       = 1'b1;
      @(negedge clk);
      strt       = 1'b0;
      finish_frame("t5", 4000, dbase);
      exp_q = {8'hA5, 8'h5A, 8'hC3, 8'h99};
      check_frame("t5", base);
      chk("t5_stable", unstable - ubase, 0);
      rand_dly = 1'b0;

      // Partial last byte; bits past nbits are set but must not be read.
      for (int i = 0; i < 32; i++) mem[i] = 1'b1;
      run_frame("t3", 10'd11, 2000, base);
      exp_q = {8'hA5, 8'hFF, 8'h07, 8'hF8};
      check_frame("t3", base);
      chk("t3_maxaddr", addr_max, 10);

      // Full image, then an oversize count that must clamp to the same frame.
      for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
      for (int i = 784; i < 1024; i++) mem[i] = 1'b1;
      build_exp(784);
      run_frame("t4", 10'd784, 5000, base);
      check_frame("t4", base);
      chk("t4_maxaddr", addr_max, 783);
      run_frame("t4c", 10'd1023, 5000, base);
      check_frame("t4c", base);
      chk("t4c_maxaddr", addr_max, 783);

      // Reset mid-frame, then a clean one-byte dump.
      base  = byte_q.size();
      nbits = 10'd128;
      strt  = 1'b1;
      @(negedge clk);
      strt  = 1'b0;
      for (int i = 0; i < 2000 && byte_q.size() < base + 3; i++) @(negedge clk);
      chk("t6_reached_byte3", byte_q.size() >= base + 3, 1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_addr", addr_rd, 0);
      chk("t6_rst_trmt", trmt, 0);
      chk("t6_rst_txdata", tx_data, 0);
      chk("t6_rst_bsy", bsy, 0);
      chk("t6_rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      build_exp(8);
      run_frame("t6", 10'd8, 2000, base);
      check_frame("t6", base);

      chk("trmt_no_double", viol, 0);
      chk("txdata_stable", unstable, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
